draw_snake: RTL

Overlay stage directly downstream of the background renderer in the VGA pipeline. Receives the 1024×768 timing bundle and the background RGB, and holds the snake body as a register array of grid cells. Applies move/grow requests once per frame during vertical blanking, detects wall and self collisions, and paints head and body cells over the incoming pixel stream.

---
 rtl/snake_pkg.sv | 38 +++
 rtl/snake_body.sv | 85 ++++++++
 rtl/draw_snake.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake overlay: grid geometry, playfield and wall
// cells, direction codes, colours, initial snake and FSM state type.
package snake_pkg;

  localparam int unsigned DEF_GRID_SIZE = 16;
  localparam int unsigned DEF_MAX_LEN   = 32;

  // Playfield cells; walls are the ring of cells just outside it.
  localparam logic [6:0] PLAY_X_MIN = 7'd13;
  localparam logic [6:0] PLAY_X_MAX = 7'd50;
  localparam logic [5:0] PLAY_Y_MIN = 6'd15;
  localparam logic [5:0] PLAY_Y_MAX = 6'd32;
  localparam logic [6:0] WALL_X_LO  = PLAY_X_MIN - 7'd1;
  localparam logic [6:0] WALL_X_HI  = PLAY_X_MAX + 7'd1;
  localparam logic [5:0] WALL_Y_LO  = PLAY_Y_MIN - 6'd1;
  localparam logic [5:0] WALL_Y_HI  = PLAY_Y_MAX + 6'd1;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [11:0] COLOR_HEAD = 12'h0_8_0;
  localparam logic [11:0] COLOR_BODY = 12'h0_f_0;
  localparam logic [11:0] COLOR_DEAD = 12'hf_0_f;

  localparam logic [6:0] INIT_X   = 7'd30;
  localparam logic [5:0] INIT_Y   = 6'd24;
  localparam int         INIT_LEN = 3;

  typedef enum logic [2:0] {StIdle, StPending, StUpdate, StCheck, StDone, StDead} state_t;

  // Initial snake lies horizontally, head rightmost; unused slots are zeroed.
  function automatic logic [6:0] init_seg_x(int i);
    return (i < INIT_LEN) ? INIT_X - 7'(i) : 7'd0;
  endfunction

endpackage

// File: rtl/snake_body.sv
// Segment array of the snake: shift/grow on a step, length counter, and the
// parallel comparators used both for pixel hits and head collision.
module snake_body
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       init,
  input  logic       step,
  input  logic       grow_en,
  input  logic [1:0] step_dir,
  input  logic [6:0] cx,
  input  logic [5:0] cy,
  output logic [6:0] head_x,
  output logic [5:0] head_y,
  output logic [5:0] length,
  output logic       pix_head,
  output logic       pix_body,
  output logic       collide
);

  logic [6:0] seg_x_q [MAX_LEN];
  logic [5:0] seg_y_q [MAX_LEN];
  logic [5:0] len_q;
  logic [6:0] new_x;
  logic [5:0] new_y;

  // Candidate head cell one step along step_dir.
  always_comb begin
    new_x = seg_x_q[0];
    new_y = seg_y_q[0];
    unique case (step_dir)
      DIR_RIGHT: new_x = seg_x_q[0] + 7'd1;
      DIR_UP:    new_y = seg_y_q[0] - 6'd1;
      DIR_LEFT:  new_x = seg_x_q[0] - 7'd1;
      DIR_DOWN:  new_y = seg_y_q[0] + 6'd1;
    endcase
  end

  // Segment shift register and length counter; init restores the start snake.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= init_seg_x(i);
        seg_y_q[i] <= INIT_Y;
      end
      len_q <= 6'(INIT_LEN);
    end else if (init) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= init_seg_x(i);
        seg_y_q[i] <= INIT_Y;
      end
      len_q <= 6'(INIT_LEN);
    end else if (step) begin
      seg_x_q[0] <= new_x;
      seg_y_q[0] <= new_y;
      for (int i = 1; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= seg_x_q[i-1];
        seg_y_q[i] <= seg_y_q[i-1];
      end
      if (grow_en && (len_q < 6'(MAX_LEN))) len_q <= len_q + 6'd1;
    end
  end

  // Pixel hits and head collision; only slots below the length take part.
  always_comb begin
    pix_head = (cx == seg_x_q[0]) && (cy == seg_y_q[0]);
    pix_body = 1'b0;
    collide  = (seg_x_q[0] == WALL_X_LO) || (seg_x_q[0] == WALL_X_HI) ||
               (seg_y_q[0] == WALL_Y_LO) || (seg_y_q[0] == WALL_Y_HI);
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if (6'(i) < len_q) begin
        if ((cx == seg_x_q[i]) && (cy == seg_y_q[i])) pix_body = 1'b1;
        if ((seg_x_q[0] == seg_x_q[i]) && (seg_y_q[0] == seg_y_q[i])) collide = 1'b1;
      end
    end
  end

  assign head_x = seg_x_q[0];
  assign head_y = seg_y_q[0];
  assign length = len_q;

endmodule

// File: rtl/draw_snake.sv
// Snake overlay stage: move/grow FSM stepping once per frame at vblank, and a
// 2-cycle render pipeline painting head and body over the background pixels.
module draw_snake
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned GRID_SIZE = DEF_GRID_SIZE
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        move_req,
  input  logic [1:0]  dir,
  input  logic        grow,
  input  logic        restart,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        move_done,
  output logic        dead,
  output logic [6:0]  head_x,
  output logic [5:0]  head_y,
  output logic [5:0]  length
);

  localparam int unsigned GRID_SHIFT = $clog2(GRID_SIZE);

  state_t      state_q;
  logic        vblnk_q;
  logic        vblnk_rise;
  logic        req_pending_q;
  logic [1:0]  req_dir_q;
  logic [1:0]  cur_dir_q;
  logic [1:0]  eff_dir;
  logic        grow_pending_q;
  logic        dead_q;
  logic        move_done_q;
  logic [6:0]  cx;
  logic [5:0]  cy;
  logic        pix_head;
  logic        pix_body;
  logic        collide;

  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, hblnk_s1, vsync_s1, vblnk_s1;
  logic [11:0] rgb_s1;
  logic        hit_head_s1, hit_body_s1;

  assign vblnk_rise = vblnk_in & ~vblnk_q;
  assign cx         = 7'(hcount_in >> GRID_SHIFT);
  assign cy         = 6'(vcount_in >> GRID_SHIFT);

  // A requested U-turn is ignored: the snake keeps its current heading.
  always_comb begin
    eff_dir = ((req_dir_q ^ 2'd2) == cur_dir_q) ? cur_dir_q : req_dir_q;
  end

  snake_body #(
    .MAX_LEN (MAX_LEN)
  ) u_body (
    .pclk     (pclk),
    .rst      (rst),
    .init     (restart),
    .step     (state_q == StUpdate),
    .grow_en  (grow_pending_q),
    .step_dir (eff_dir),
    .cx       (cx),
    .cy       (cy),
    .head_x   (head_x),
    .head_y   (head_y),
    .length   (length),
    .pix_head (pix_head),
    .pix_body (pix_body),
    .collide  (collide)
  );

  // Vblank edge detector.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk_in;
  end

  // Step FSM with request latches; restart beats every other input.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      req_pending_q  <= 1'b0;
      req_dir_q      <= DIR_RIGHT;
      cur_dir_q      <= DIR_RIGHT;
      grow_pending_q <= 1'b0;
      dead_q         <= 1'b0;
      move_done_q    <= 1'b0;
    end else if (restart) begin
      state_q        <= StIdle;
      req_pending_q  <= 1'b0;
      req_dir_q      <= DIR_RIGHT;
      cur_dir_q      <= DIR_RIGHT;
      grow_pending_q <= 1'b0;
      dead_q         <= 1'b0;
      move_done_q    <= 1'b0;
    end else begin
      move_done_q <= 1'b0;
      if (state_q != StDead) begin
        // Latest request wins; one arriving mid-step waits for the next frame.
        if (move_req) begin
          req_pending_q <= 1'b1;
          req_dir_q     <= dir;
        end
        if (grow) grow_pending_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: if (move_req || req_pending_q) state_q <= StPending;
        StPending: begin
          if (vblnk_rise) begin
            state_q       <= StUpdate;
            req_pending_q <= 1'b0;
          end
        end
        StUpdate: begin
          cur_dir_q      <= eff_dir;
          grow_pending_q <= grow;
          state_q        <= StCheck;
        end
        StCheck: begin
          if (collide) begin
            dead_q  <= 1'b1;
            state_q <= StDead;
          end else begin
            move_done_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        StDead:  state_q <= StDead;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Render stage 1: delay the bundle and register the cell hits.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_s1   <= '0;
      vcount_s1   <= '0;
      hsync_s1    <= 1'b0;
      hblnk_s1    <= 1'b0;
      vsync_s1    <= 1'b0;
      vblnk_s1    <= 1'b0;
      rgb_s1      <= '0;
      hit_head_s1 <= 1'b0;
      hit_body_s1 <= 1'b0;
    end else begin
      hcount_s1   <= hcount_in;
      vcount_s1   <= vcount_in;
      hsync_s1    <= hsync_in;
      hblnk_s1    <= hblnk_in;
      vsync_s1    <= vsync_in;
      vblnk_s1    <= vblnk_in;
      rgb_s1      <= rgb_in;
      hit_head_s1 <= pix_head;
      hit_body_s1 <= pix_body;
    end
  end

  // Render stage 2: colour priority blank > head > body > background.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      hblnk_out  <= hblnk_s1;
      vsync_out  <= vsync_s1;
      vblnk_out  <= vblnk_s1;
      if (hblnk_s1 || vblnk_s1) rgb_out <= rgb_s1;
      else if (hit_head_s1)     rgb_out <= dead_q ? COLOR_DEAD : COLOR_HEAD;
      else if (hit_body_s1)     rgb_out <= COLOR_BODY;
      else                      rgb_out <= rgb_s1;
    end
  end

  assign dead      = dead_q;
  assign move_done = move_done_q;

endmodule
